// File: rtl/core_mgmt_initiator.sv
// Core-management bus initiator: turns halt/run/read commands into single
// write or read transactions on the management slave and returns one response.
module core_mgmt_initiator #(
    parameter int          NUM_CPUS  = 4,
    parameter logic [31:0] ADDR      = 32'h1000_0000,
    parameter logic [31:0] HALT_CODE = 32'h0000_0010,
    parameter logic [31:0] RUN_CODE  = 32'h0000_0020,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwr,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_core,
    input  logic [4:0]  cmd_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        w_valid,
    output logic [31:0] wdata,
    output logic [31:0] waddr,
    output logic        arvalid,
    output logic [31:0] raddr,
    input  logic        rvalid,
    input  logic [31:0] rdata
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR      = 3'd1;
    localparam logic [2:0] RD_REQ  = 3'd2;
    localparam logic [2:0] RD_WAIT = 3'd3;
    localparam logic [2:0] RSP     = 3'd4;

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          cmd_bad;

    assign busy    = (state != IDLE);
    assign cmd_bad = (cmd_op == 2'b11) || ({30'b0, cmd_core} >= 32'(NUM_CPUS)) || !pwr;

    // cmd_ready is registered so it first rises on the clock edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            w_valid   <= 1'b0;
            arvalid   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            wdata     <= '0;
            waddr     <= '0;
            raddr     <= '0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_bad) begin
                            state     <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end else if (!cmd_op[1]) begin
                            state   <= WR;
                            w_valid <= 1'b1;
                            waddr   <= ADDR;
                            wdata   <= (cmd_op[0] ? RUN_CODE : HALT_CODE) + {30'b0, cmd_core};
                        end else begin
                            state   <= RD_REQ;
                            arvalid <= 1'b1;
                            raddr   <= {27'b0, cmd_addr};
                            cnt     <= '0;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WR: begin
                    state     <= RSP;
                    w_valid   <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_data  <= wdata;
                end
                RD_REQ, RD_WAIT: begin
                    // Power loss outranks a same-cycle rvalid; timeout fires on the last counted cycle.
                    if (!pwr || (!rvalid && cnt == CW'(TIMEOUT - 1))) begin
                        state     <= RSP;
                        arvalid   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                    end else if (rvalid) begin
                        state     <= RSP;
                        arvalid   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= rdata;
                    end else begin
                        state <= RD_WAIT;
                        cnt   <= cnt + CW'(1);
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                    w_valid   <= 1'b0;
                    arvalid   <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/core_mgmt_initiator.md
CORE_MGMT_INITIATOR -- requirements
Module: core_mgmt_initiator

Interface
REQ-001 SHALL have parameter NUM_CPUS, default 4: number of managed cores.
REQ-002 SHALL have parameter ADDR, default 32'h1000_0000: core-management command address.
REQ-003 SHALL have parameter HALT_CODE, default 32'h0000_0010: halt command base; wdata = HALT_CODE + core.
REQ-004 SHALL have parameter RUN_CODE, default 32'h0000_0020: release command base; wdata = RUN_CODE + core.
REQ-005 SHALL have parameter TIMEOUT, default 16: maximum read-wait cycles.
REQ-006 SHALL have ports: clk  in  1  clock; rst  in  1  asynchronous active-low reset; pwr  in  1  management domain powered.
REQ-007 SHALL have ports: cmd_valid  in  1  request; cmd_ready  out  1  request accepted; cmd_op  in  2  00 halt, 01 run, 10 read, 11 reserved; cmd_core  in  2  target core; cmd_addr  in  5  read map index.
REQ-008 SHALL have ports: rsp_valid  out  1  response; rsp_ready  in  1  response taken; rsp_data  out  32  result; rsp_err  out  1  failed; busy  out  1  command in flight.
REQ-009 SHALL have ports: w_valid  out  1; wdata  out  32; waddr  out  32; arvalid  out  1; raddr  out  32; rvalid  in  1; rdata  in  32; these drive the management slave's write and read channels.

Function
REQ-010 SHALL implement states IDLE, WR, RD_REQ, RD_WAIT, RSP; busy = (state != IDLE).
REQ-011 SHALL drive cmd_ready=1 only in IDLE; handshake on cmd_valid & cmd_ready; op, core and addr latched at handshake.
REQ-012 SHALL go IDLE->RSP with rsp_err=1, rsp_data=0 and no bus activity when, at handshake, cmd_op=11, cmd_core>=NUM_CPUS, or pwr=0.
REQ-013 SHALL go IDLE->WR for ops 00/01; in WR, w_valid=1 for exactly one cycle, waddr=ADDR, wdata=code+core; then RSP with rsp_err=0, rsp_data=wdata.
REQ-014 SHALL go IDLE->RD_REQ for op 10; arvalid=1, raddr={27'b0,addr}, held through RD_WAIT until completion.
REQ-015 SHALL, in RD_REQ or RD_WAIT, capture rdata into rsp_data on the first cycle rvalid=1 and go to RSP with rsp_err=0; in RD_REQ without rvalid, go to RD_WAIT.
REQ-016 SHALL count arvalid-high cycles; after TIMEOUT cycles with no rvalid, deassert arvalid and go to RSP with rsp_err=1, rsp_data=0.
REQ-017 SHALL abort any read when pwr=0 in RD_REQ/RD_WAIT: next state RSP, rsp_err=1, rsp_data=0; rvalid in the same cycle is ignored.
REQ-018 SHALL hold rsp_valid, rsp_data and rsp_err stable in RSP until rsp_ready=1, then return to IDLE; back-to-back commands therefore need at least one IDLE cycle.
REQ-019 SHALL ignore rvalid/rdata outside RD_REQ and RD_WAIT.
REQ-020 SHALL give latency: handshake at cycle N -> w_valid or arvalid at N+1 -> rsp_valid at N+2 when the read returns immediately.
REQ-021 SHALL drive w_valid and arvalid mutually exclusively, and never both within one command.

Reset
REQ-022 SHALL, while rst=0, asynchronously force state IDLE, w_valid=arvalid=rsp_valid=rsp_err=cmd_ready=busy=0, and wdata=waddr=raddr=rsp_data=0.
REQ-023 SHALL discard an in-flight command without a response when rst asserts mid-operation.
REQ-024 SHALL assert cmd_ready in the first clk edge after rst deasserts.

Verification
REQ-025 SHALL be verified by: halt core 1, pwr=1 -> one-cycle w_valid, waddr=32'h1000_0000, wdata=32'h11; then rsp_valid, rsp_err=0, rsp_data=32'h11.
REQ-026 SHALL be verified by: read addr 4 with rvalid=1 in the same cycle, rdata=32'h1 -> rsp_data=32'h1 at N+2, arvalid high exactly one cycle.
REQ-027 SHALL be verified by: read with rvalid never asserted -> arvalid high 16 cycles, then rsp_err=1, rsp_data=0.
REQ-028 SHALL be verified by: cmd_op=11, or pwr=0 at handshake -> no w_valid/arvalid; rsp_err=1.
REQ-029 SHALL be verified by: rsp_ready held 0 for 5 cycles -> response stable, cmd_ready=0; rsp_ready=1 -> IDLE next cycle.
REQ-030 SHALL be verified by: rst asserted during RD_WAIT -> all outputs 0 immediately; no rsp_valid after release; cmd_ready=1 one edge after release.
